// File: rtl/alu_op_sequencer.sv
// Command sequencer and 4x8 register file feeding an external 8-bit ALU.
// Takes one command per handshake, registers ALU operands, writes back the result or an immediate.
module alu_op_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_ldi,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_ra,
  input  logic [1:0] cmd_rb,
  input  logic [7:0] cmd_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       done,
  output logic       zero
);

  // state | meaning
  // IDLE  | ready; accept latches rd and either operands (ALU) or the immediate (LDI)
  // EXEC  | ALU sees stable registered operands; capture alu_out into result
  // WB    | done pulse; R[rd] and zero updated on the closing edge
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] regs [4];
  logic [7:0] result;
  logic [1:0] rd_q;
  logic       accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // cmd_ready is gated by rst_n so it reads 0 for the whole reset window.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = rst_n;
        accept    = cmd_valid && rst_n;
        if (accept) begin
          state_nxt = cmd_ldi ? WB : EXEC;
        end
      end
      EXEC: begin
        state_nxt = WB;
      end
      WB: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Sources are sampled at accept, so a command whose rd aliases ra/rb uses the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 8'h00;
      end
      alu_a   <= 8'h00;
      alu_b   <= 8'h00;
      alu_sel <= 3'b000;
      result  <= 8'h00;
      rd_q    <= 2'd0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rd_q <= cmd_rd;
            if (cmd_ldi) begin
              result <= cmd_imm;
            end else begin
              alu_a   <= regs[cmd_ra];
              alu_b   <= regs[cmd_rb];
              alu_sel <= cmd_op;
            end
          end
        end
        EXEC: begin
          result <= alu_out;
        end
        WB: begin
          regs[rd_q] <= result;
          zero       <= (result == 8'h00);
        end
        default: begin
        end
      endcase
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: acts as the ALU, issues directed and random commands,
// and scores every write-back against an array-based register model.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_ldi;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_ra;
  logic [1:0] cmd_rb;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_out;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       done;
  logic       zero;

  logic [1:0] stim_addr;
  logic [1:0] mon_addr;
  logic       use_mon;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a;
      3'd5:    return {a[6:0], 1'b0};
      3'd6:    return {1'b0, a[7:1]};
      default: return 8'h00;
    endcase
  endfunction

  assign alu_out  = alu_fn(alu_sel, alu_a, alu_b);
  assign dbg_addr = use_mon ? mon_addr : stim_addr;

  alu_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ldi   (cmd_ldi),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_ra    (cmd_ra),
    .cmd_rb    (cmd_rb),
    .cmd_imm   (cmd_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .done      (done),
    .zero      (zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] rd;
    logic [7:0] val;
    logic       ldi;
    int         t;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mregs [4];
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [2:0] m_s;
  int         cyc = 0;
  int         last_acc = 0;
  logic       last_ldi = 1'b0;
  logic       have_prev = 1'b0;
  logic       streak = 1'b0;
  int         n_done = 0;
  logic       pend = 1'b0;
  logic [7:0] pend_val = 8'h00;
  logic       last_zero = 1'b0;

  // Model updates on the accepting edge; checking happens on the following falling edges.
  initial begin
    exp_t e;
    mon_addr = 2'd0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        m_a = 8'h00;
        m_b = 8'h00;
        m_s = 3'd0;
        sb.delete();
        have_prev = 1'b0;
        streak    = 1'b0;
      end else if (cmd_valid && cmd_ready) begin
        e.ldi = cmd_ldi;
        e.rd  = cmd_rd;
        e.t   = cyc;
        if (cmd_ldi) begin
          e.val = cmd_imm;
        end else begin
          e.val = alu_fn(cmd_op, mregs[cmd_ra], mregs[cmd_rb]);
          m_a   = mregs[cmd_ra];
          m_b   = mregs[cmd_rb];
          m_s   = cmd_op;
        end
        e.a = m_a;
        e.b = m_b;
        e.sel = m_s;
        mregs[cmd_rd] = e.val;
        sb.push_back(e);
        if (have_prev && streak) chk("accept_gap", cyc - last_acc, last_ldi ? 2 : 3);
        have_prev = 1'b1;
        streak    = 1'b1;
        last_acc  = cyc;
        last_ldi  = cmd_ldi;
      end else if (!cmd_valid) begin
        streak = 1'b0;
      end

      @(negedge clk);
      if (!rst_n) begin
        pend      = 1'b0;
        last_zero = 1'b0;
      end else begin
        if (pend) begin
          chk("wb_value", dbg_data, pend_val);
          chk("zero_flag", zero, pend_val == 8'h00);
          last_zero = (pend_val == 8'h00);
          pend      = 1'b0;
        end
        if (done) begin
          n_done++;
          chk("done_in_idle", cmd_ready, 0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected: done=1 with no outstanding command (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk("done_latency", cyc - e.t, e.ldi ? 0 : 1);
            chk("alu_a_hold", alu_a, e.a);
            chk("alu_b_hold", alu_b, e.b);
            chk("alu_sel_hold", alu_sel, e.sel);
            chk("zero_before_wb", zero, last_zero);
            pend     = 1'b1;
            pend_val = e.val;
            mon_addr = e.rd;
          end
        end
      end
    end
  end

  task automatic send(input logic ldi, input logic [2:0] op, input logic [1:0] rd,
                      input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ldi   = ldi;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_ra    = ra;
    cmd_rb    = rb;
    cmd_imm   = imm;
    do begin
      @(posedge clk);
      n++;
    end while (!cmd_ready && n < 20);
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles", n);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!(sb.size() == 0 && !pend && cmd_ready) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: outstanding=%0d pend=%0d", sb.size(), pend);
    end
  endtask

  task automatic expect_reg(input string name, input logic [1:0] idx, input logic [7:0] val);
    use_mon   = 1'b0;
    stim_addr = idx;
    #1;
    chk(name, dbg_data, val);
    use_mon = 1'b1;
  endtask

  task automatic exec_check(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_alu_sel", alu_sel, sel);
  endtask

  initial begin
    logic [2:0] ops [6];
    logic [7:0] res [6];
    int n0;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
    ops = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    res = '{8'h01, 8'h8F, 8'h81, 8'h02, 8'h40, 8'h00};
  end

  initial begin
    logic [2:0] ops [6];
    logic [7:0] res [6];
    int n0;
    ops = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    res = '{8'h01, 8'h8F, 8'h81, 8'h02, 8'h40, 8'h00};
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_ldi   = 1'b0;
    cmd_op    = 3'd0;
    cmd_rd    = 2'd0;
    cmd_ra    = 2'd0;
    cmd_rb    = 2'd0;
    cmd_imm   = 8'h00;
    use_mon   = 1'b1;
    stim_addr = 2'd0;

    repeat (3) @(negedge clk);
    chk("ready_in_reset", cmd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);
    chk("reset_alu_a", alu_a, 8'h00);
    chk("reset_alu_b", alu_b, 8'h00);
    chk("reset_alu_sel", alu_sel, 3'd0);
    chk("reset_done", done, 0);
    chk("reset_zero", zero, 0);
    for (int i = 0; i < 4; i++) expect_reg("reset_reg", 2'(i), 8'h00);

    // Reset in the middle of EXEC aborts the command and clears everything.
    send(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h05);
    send(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h03);
    drain();
    send(1'b0, 3'd0, 2'd0, 2'd1, 2'd2, 8'h00);
    exec_check(8'h05, 8'h03, 3'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_alu_a", alu_a, 8'h00);
    chk("abort_alu_b", alu_b, 8'h00);
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 0);
    for (int i = 0; i < 4; i++) expect_reg("abort_reg", 2'(i), 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_release", cmd_ready, 1);
    expect_reg("abort_r0_unwritten", 2'd0, 8'h00);

    send(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h05);
    send(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h03);
    send(1'b0, 3'd0, 2'd0, 2'd1, 2'd2, 8'h00);
    exec_check(8'h05, 8'h03, 3'd0);
    drain();
    expect_reg("add_r0", 2'd0, 8'h08);
    chk("add_zero", zero, 0);

    send(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'hFF);
    send(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h01);
    send(1'b0, 3'd0, 2'd3, 2'd1, 2'd2, 8'h00);
    drain();
    expect_reg("wrap_r3", 2'd3, 8'h00);
    chk("wrap_zero", zero, 1);
    send(1'b0, 3'd1, 2'd3, 2'd1, 2'd2, 8'h00);
    drain();
    expect_reg("sub_r3", 2'd3, 8'hFE);
    chk("sub_zero", zero, 0);

    send(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h81);
    send(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h0F);
    for (int i = 0; i < 6; i++) begin
      send(1'b0, ops[i], 2'd3, 2'd1, 2'd2, 8'h00);
      exec_check(8'h81, 8'h0F, ops[i]);
      drain();
      expect_reg("sel_result", 2'd3, res[i]);
    end

    send(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h21);
    send(1'b0, 3'd0, 2'd1, 2'd1, 2'd1, 8'h00);
    drain();
    expect_reg("alias_r1", 2'd1, 8'h42);

    // Back-to-back with cmd_valid held high across all three.
    n0 = n_done;
    send(1'b0, 3'd0, 2'd2, 2'd1, 2'd1, 8'h00);
    send(1'b1, 3'd5, 2'd3, 2'd0, 2'd0, 8'h77);
    send(1'b0, 3'd3, 2'd0, 2'd2, 2'd3, 8'h00);
    drain();
    chk("b2b_done_count", n_done - n0, 3);
    expect_reg("b2b_r0", 2'd0, 8'hF7);

    for (int i = 0; i < 80; i++) begin
      send($urandom_range(0, 9) < 3, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    drain();
    for (int i = 0; i < 4; i++) expect_reg("final_reg", 2'(i), mregs[i]);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
